// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the up/down counter library.
// clamp_load limits a parallel-load value to the top of the count range.
package cnt_pkg;

  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulus);
    return (val < modulus) ? val : modulus - 1;
  endfunction

endpackage

// File: rtl/sync_updown_counter_tff_cell.sv
// Single T flip-flop: toggles on rising clk when t=1, async active-high clear.
// One instance per counter bit.
module tff_cell (
  input  logic t,
  input  logic clk,
  input  logic rst,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Synchronous modulo-N up/down counter on per-bit T flops with load, enable and wrap pulse.
// Define CNT_SATURATE_EN to hold at the range limits instead of wrapping (wrap becomes a saturation flag).
module sync_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] tgl;
  logic             wrap_q;
  logic             wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
    end else if (en) begin
      if (up_dn == CNT_UP) begin
        if (cnt_q == MAX_VAL) begin
          wrap_d = 1'b1;
`ifdef CNT_SATURATE_EN
          cnt_d  = cnt_q;
`else
          cnt_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          wrap_d = 1'b1;
`ifdef CNT_SATURATE_EN
          cnt_d  = cnt_q;
`else
          cnt_d  = MAX_VAL;
`endif
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  // Each bit flips exactly where the chosen next state differs from the present one.
  assign tgl = cnt_d ^ cnt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_bit (
      .t  (tgl[i]),
      .clk(clk),
      .rst(rst),
      .q  (cnt_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter (WIDTH=3/MODULUS=6 and WIDTH=4/MODULUS=16), with a per-cycle model check.
`timescale 1ns/1ps
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] q;
  logic       wrap;
  logic       en16 = 1'b0, up16 = 1'b1, load16 = 1'b0;
  logic [3:0] lv16 = '0;
  logic [3:0] q16;
  logic       wrap16;

  int n_cmp  = 0;
  int n_fail = 0;

  int mq = 0, mq16 = 0;
  bit mw = 1'b0, mw16 = 1'b0;

`ifdef CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(3), .MODULUS(6)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q), .wrap(wrap)
  );

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en16), .up_dn(up16), .load(load16),
    .load_val(lv16), .q(q16), .wrap(wrap16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next count from the range rules: modular arithmetic, or clipping in the saturating build.
  function automatic int model_next(input int cur, input bit ld, input int lv, input bit e,
                                    input bit u, input int m, output bit w);
    w = 1'b0;
    if (ld) return (lv < m) ? lv : m - 1;
    if (!e) return cur;
    if (u) begin
      w = (cur + 1 == m);
      if (SAT) return w ? cur : cur + 1;
      return (cur + 1) % m;
    end
    w = (cur == 0);
    if (SAT) return w ? cur : cur - 1;
    return (cur + m - 1) % m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq = 0; mw = 1'b0; mq16 = 0; mw16 = 1'b0;
    end else begin
      mq   = model_next(mq, load, int'(load_val), en, up_dn, 6, mw);
      mq16 = model_next(mq16, load16, int'(lv16), en16, up16, 16, mw16);
    end
  end

  always @(posedge clk) begin
    #2;
    check("model_q",      32'(q),      32'(mq));
    check("model_wrap",   32'(wrap),   32'(mw));
    check("model_q16",    32'(q16),    32'(mq16));
    check("model_wrap16", 32'(wrap16), 32'(mw16));
  end

  task automatic edge_chk(input string name, input int eq, input bit ew);
    @(posedge clk);
    #3;
    check({name, "_q"},    32'(q),    32'(eq));
    check({name, "_wrap"}, 32'(wrap), 32'(ew));
  endtask

  initial begin
    int s1q[8], s1w[8], s2q[4], s2w[4], s4q[4];
    if (SAT) begin
      s1q = '{1, 2, 3, 4, 5, 5, 5, 5}; s1w = '{0, 0, 0, 0, 0, 1, 1, 1};
      s2q = '{1, 0, 0, 0};             s2w = '{0, 0, 1, 1};
    end else begin
      s1q = '{1, 2, 3, 4, 5, 0, 1, 2}; s1w = '{0, 0, 0, 0, 0, 1, 0, 0};
      s2q = '{1, 0, 5, 4};             s2w = '{0, 0, 1, 0};
    end
    s4q = '{4, 3, 4, 3};

    // 1: reset, then count up through the wrap point
    rst = 1'b1;
    #1;
    check("rst_q", 32'(q), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 8; i++) edge_chk($sformatf("s1_%0d", i), s1q[i], s1w[i]);

    // 2: load 2, count down through zero
    @(negedge clk); load = 1'b1; load_val = 3'd2; en = 1'b0;
    edge_chk("s2_load", 2, 1'b0);
    @(negedge clk); load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 4; i++) edge_chk($sformatf("s2_%0d", i), s2q[i], s2w[i]);

    // 3: out-of-range load clamps, beats en
    @(negedge clk); load = 1'b1; load_val = 3'd7; en = 1'b1; up_dn = 1'b1;
    edge_chk("s3_clamp", 5, 1'b0);

    // 4: direction change every cycle from 3
    @(negedge clk); load = 1'b1; load_val = 3'd3; en = 1'b0;
    edge_chk("s4_load", 3, 1'b0);
    @(negedge clk); load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      edge_chk($sformatf("s4_%0d", i), s4q[i], 1'b0);
      @(negedge clk);
    end

    // 5: asynchronous reset between edges at q=4
    load = 1'b1; load_val = 3'd4; en = 1'b0;
    edge_chk("s5_load", 4, 1'b0);
    rst = 1'b1;
    #1;
    check("s5_async_q", 32'(q), 32'd0);
    check("s5_async_wrap", 32'(wrap), 32'd0);
    @(negedge clk); load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 2; i++) edge_chk($sformatf("s5_hold%0d", i), 0, 1'b0);
    @(negedge clk); rst = 1'b0; en = 1'b0;

    // 6: full-range 4-bit counter from 15
    load16 = 1'b1; lv16 = 4'd15;
    @(posedge clk); #3;
    check("s6_load_q16", 32'(q16), 32'd15);
    @(negedge clk); load16 = 1'b0; en16 = 1'b1; up16 = 1'b1;
    @(posedge clk); #3;
    check("s6_wrap_q16", 32'(q16), SAT ? 32'd15 : 32'd0);
    check("s6_wrap_w16", 32'(wrap16), 32'd1);
    @(negedge clk); en16 = 1'b0;
    @(posedge clk); #3;
    check("s6_hold_q16", 32'(q16), SAT ? 32'd15 : 32'd0);
    check("s6_hold_w16", 32'(wrap16), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
